// File: rtl/fft16_result_serializer.sv
// Captures the 16 parallel FFT bins on a finished transform and replays them one bin per beat on a valid/ready stream.
// Optional magnitude output (alpha-max-beta-min estimate) is enabled with `define FFT_SER_MAG_EN.
module fft16_result_serializer #(
  parameter int N        = 16,
  parameter int Q        = 8,
  parameter int BIN_LAST = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_FFT_cycle_done,
  input  logic [16*N-1:0]   i_bins_re,
  input  logic [16*N-1:0]   i_bins_im,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [N-1:0]      o_data_re,
  output logic [N-1:0]      o_data_im,
  output logic [3:0]        o_bin_idx,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_overrun
`ifdef FFT_SER_MAG_EN
  ,
  output logic [N-1:0]      o_mag
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(BIN_LAST);

  if (BIN_LAST < 0 || BIN_LAST > 15 || Q >= N) begin : g_bad_cfg
    $error("fft16_result_serializer: BIN_LAST must be 0..15 and Q below N");
  end

  state_t         state_r;
  state_t         state_s;
  logic           done_d_r;
  logic [3:0]     idx_r;
  logic [N-1:0]   bank_re_r [16];
  logic [N-1:0]   bank_im_r [16];
  logic [N-1:0]   data_re_r;
  logic [N-1:0]   data_im_r;
  logic           overrun_r;

  logic           done_edge_s;
  logic           handshake_s;
  logic           final_s;
  logic           capture_s;
  logic           drop_s;
  logic           valid_s;
  logic           busy_s;
  logic           last_s;

  // Frame-edge detect and handshake decode; a new frame is only taken when the replay is idle or just finishing.
  always_comb begin
    done_edge_s = i_FFT_cycle_done & ~done_d_r;
    handshake_s = (state_r == ST_SEND) & i_ready;
    final_s     = handshake_s & (idx_r == LAST_IDX);
    capture_s   = done_edge_s & ((state_r == ST_IDLE) | final_s);
    drop_s      = done_edge_s & ~capture_s;
  end

  // State register; reset leaves the done delay high so a held done level is not seen as a new frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r  <= ST_IDLE;
      done_d_r <= 1'b1;
    end else begin
      state_r  <= state_s;
      done_d_r <= i_FFT_cycle_done;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (capture_s) state_s = ST_SEND;
        else           state_s = ST_IDLE;
      end
      ST_SEND: begin
        if (final_s && !capture_s) state_s = ST_IDLE;
        else                       state_s = ST_SEND;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode from registered state and index.
  always_comb begin
    valid_s = 1'b0;
    busy_s  = 1'b0;
    last_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        valid_s = 1'b0;
        busy_s  = 1'b0;
        last_s  = 1'b0;
      end
      ST_SEND: begin
        valid_s = 1'b1;
        busy_s  = 1'b1;
        last_s  = (idx_r == LAST_IDX);
      end
      default: begin
        valid_s = 1'b0;
        busy_s  = 1'b0;
        last_s  = 1'b0;
      end
    endcase
  end

  // Bin bank: all 16 entries are loaded in one cycle on capture, even those above BIN_LAST.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < 16; k++) begin
        bank_re_r[k] <= '0;
        bank_im_r[k] <= '0;
      end
    end else if (capture_s) begin
      for (int k = 0; k < 16; k++) begin
        bank_re_r[k] <= i_bins_re[k*N +: N];
        bank_im_r[k] <= i_bins_im[k*N +: N];
      end
    end else begin
      for (int k = 0; k < 16; k++) begin
        bank_re_r[k] <= bank_re_r[k];
        bank_im_r[k] <= bank_im_r[k];
      end
    end
  end

  // Beat index and output data registers; the data register mirrors bank[idx] so a stall holds everything.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx_r     <= 4'd0;
      data_re_r <= '0;
      data_im_r <= '0;
    end else if (capture_s) begin
      idx_r     <= 4'd0;
      data_re_r <= i_bins_re[0 +: N];
      data_im_r <= i_bins_im[0 +: N];
    end else if (final_s) begin
      idx_r     <= 4'd0;
      data_re_r <= data_re_r;
      data_im_r <= data_im_r;
    end else if (handshake_s) begin
      idx_r     <= idx_r + 4'd1;
      data_re_r <= bank_re_r[idx_r + 4'd1];
      data_im_r <= bank_im_r[idx_r + 4'd1];
    end else begin
      idx_r     <= idx_r;
      data_re_r <= data_re_r;
      data_im_r <= data_im_r;
    end
  end

  // Sticky overrun flag, cleared only by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      overrun_r <= 1'b0;
    end else if (drop_s) begin
      overrun_r <= 1'b1;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign o_valid   = valid_s;
  assign o_busy    = busy_s;
  assign o_last    = last_s;
  assign o_bin_idx = idx_r;
  assign o_data_re = data_re_r;
  assign o_data_im = data_im_r;
  assign o_overrun = overrun_r;

`ifdef FFT_SER_MAG_EN
  localparam logic [N-1:0] MAG_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MAG_MIN = {1'b1, {(N-1){1'b0}}};

  function automatic logic [N-1:0] abs_sat(input logic [N-1:0] v);
    logic [N-1:0] res;
    if (!v[N-1])          res = v;
    else if (v == MAG_MIN) res = MAG_MAX;
    else                  res = ~v + {{(N-1){1'b0}}, 1'b1};
    return res;
  endfunction

  // max(|re|,|im|) + min(|re|,|im|)/2, saturated to the largest positive value.
  function automatic logic [N-1:0] mag_est(input logic [N-1:0] re, input logic [N-1:0] im);
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic [N:0]   sum;
    logic [N-1:0] res;
    a = abs_sat(re);
    b = abs_sat(im);
    if (a > b) begin
      hi = a;
      lo = b;
    end else begin
      hi = b;
      lo = a;
    end
    sum = {1'b0, hi} + {2'b00, lo[N-1:1]};
    if (sum > {1'b0, MAG_MAX}) res = MAG_MAX;
    else                       res = sum[N-1:0];
    return res;
  endfunction

  assign o_mag = mag_est(data_re_r, data_im_r);
`endif

endmodule

// File: tb/tb_fft16_result_serializer.sv
// Self-checking bench for fft16_result_serializer: two instances (BIN_LAST 15 and 7) against a frame/position reference model.
module tb_fft16_result_serializer;

  logic              clk;
  logic              rst;
  logic              done;
  logic              ready;
  logic [255:0]      bins_re;
  logic [255:0]      bins_im;

  logic              v0, v1, l0, l1, b0, b1, r0, r1;
  logic [15:0]       dre0, dre1, dim0, dim1;
  logic [3:0]        idx0, idx1;
`ifdef FFT_SER_MAG_EN
  logic [15:0]       mag0, mag1;
  logic [15:0]       omag [2];
  assign omag[0] = mag0;
  assign omag[1] = mag1;
`endif

  fft16_result_serializer #(.N(16), .Q(8), .BIN_LAST(15)) dut (
    .i_clk(clk), .i_rst(rst), .i_FFT_cycle_done(done),
    .i_bins_re(bins_re), .i_bins_im(bins_im), .i_ready(ready),
    .o_valid(v0), .o_data_re(dre0), .o_data_im(dim0), .o_bin_idx(idx0),
    .o_last(l0), .o_busy(b0), .o_overrun(r0)
`ifdef FFT_SER_MAG_EN
    , .o_mag(mag0)
`endif
  );

  fft16_result_serializer #(.N(16), .Q(8), .BIN_LAST(7)) dut7 (
    .i_clk(clk), .i_rst(rst), .i_FFT_cycle_done(done),
    .i_bins_re(bins_re), .i_bins_im(bins_im), .i_ready(ready),
    .o_valid(v1), .o_data_re(dre1), .o_data_im(dim1), .o_bin_idx(idx1),
    .o_last(l1), .o_busy(b1), .o_overrun(r1)
`ifdef FFT_SER_MAG_EN
    , .o_mag(mag1)
`endif
  );

  logic              ov [2];
  logic              olast [2];
  logic              obusy [2];
  logic              oovr [2];
  logic [15:0]       ore [2];
  logic [15:0]       oim [2];
  logic [3:0]        oidx [2];
  assign ov[0] = v0;    assign ov[1] = v1;
  assign olast[0] = l0; assign olast[1] = l1;
  assign obusy[0] = b0; assign obusy[1] = b1;
  assign oovr[0] = r0;  assign oovr[1] = r1;
  assign ore[0] = dre0; assign ore[1] = dre1;
  assign oim[0] = dim0; assign oim[1] = dim1;
  assign oidx[0] = idx0; assign oidx[1] = idx1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: the frame being replayed and the position in it
  bit          act [2];
  int          pos [2];
  int          lastm [2];
  logic [15:0] fre [2][16];
  logic [15:0] fim [2][16];
  bit          ovr [2];
  int          hs_cnt [2];
  bit          done_prev;

  typedef struct {
    logic       done;
    logic       ready;
    logic       exp_valid;
    logic [3:0] exp_idx;
    logic       exp_last;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input int m, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s dut%0d: got %0h want %0h at %0t", name, m, act_v, exp_v, $time);
    end
  endtask

  function automatic int ref_mag(input logic [15:0] re, input logic [15:0] im);
    int a;
    int b;
    int m;
    a = $signed(re);
    b = $signed(im);
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    if (a > 32767) a = 32767;
    if (b > 32767) b = 32767;
    m = (a > b ? a : b) + (a > b ? b : a) / 2;
    if (m > 32767) m = 32767;
    return m;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      act[m] = 1'b0;
      pos[m] = 0;
      ovr[m] = 1'b0;
      hs_cnt[m] = 0;
    end
    done_prev = 1'b1;
  endtask

  task automatic model_edge();
    bit e;
    bit hs;
    bit fin;
    e = done & ~done_prev;
    for (int m = 0; m < 2; m++) begin
      hs  = act[m] && ready;
      fin = hs && (pos[m] == lastm[m]);
      if (hs) hs_cnt[m]++;
      if (e && (!act[m] || fin)) begin
        for (int k = 0; k < 16; k++) begin
          fre[m][k] = bins_re[k*16 +: 16];
          fim[m][k] = bins_im[k*16 +: 16];
        end
        act[m] = 1'b1;
        pos[m] = 0;
      end else begin
        if (e) ovr[m] = 1'b1;
        if (fin) act[m] = 1'b0;
        else if (hs) pos[m]++;
      end
    end
    done_prev = done;
  endtask

  task automatic check_model();
    for (int m = 0; m < 2; m++) begin
      chk("valid", m, 32'(ov[m]), 32'(act[m]));
      chk("busy", m, 32'(obusy[m]), 32'(act[m]));
      chk("overrun", m, 32'(oovr[m]), 32'(ovr[m]));
      chk("last", m, 32'(olast[m]), 32'(act[m] && pos[m] == lastm[m]));
      if (act[m]) begin
        chk("idx", m, 32'(oidx[m]), 32'(pos[m]));
        chk("data_re", m, 32'(ore[m]), 32'(fre[m][pos[m]]));
        chk("data_im", m, 32'(oim[m]), 32'(fim[m][pos[m]]));
`ifdef FFT_SER_MAG_EN
        chk("mag", m, 32'(omag[m]), 32'(ref_mag(fre[m][pos[m]], fim[m][pos[m]])));
`endif
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic check_zero(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk({tag, "_valid"}, m, 32'(ov[m]), 32'd0);
      chk({tag, "_idx"}, m, 32'(oidx[m]), 32'd0);
      chk({tag, "_last"}, m, 32'(olast[m]), 32'd0);
      chk({tag, "_busy"}, m, 32'(obusy[m]), 32'd0);
      chk({tag, "_overrun"}, m, 32'(oovr[m]), 32'd0);
      chk({tag, "_re"}, m, 32'(ore[m]), 32'd0);
      chk({tag, "_im"}, m, 32'(oim[m]), 32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic frame_k();
    for (int k = 0; k < 16; k++) begin
      bins_re[k*16 +: 16] = 16'(k * 256);
      bins_im[k*16 +: 16] = 16'(-k);
    end
  endtask

  task automatic frame_rand();
    for (int k = 0; k < 16; k++) begin
      bins_re[k*16 +: 16] = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      bins_im[k*16 +: 16] = 16'($urandom);
    end
  endtask

  task automatic pulse_done();
    done = 1'b0;
    step();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  initial begin
    bit fired;
    rst = 1'b1;
    done = 1'b1;
    ready = 1'b0;
    bins_re = '0;
    bins_im = '0;
    lastm[0] = 15;
    lastm[1] = 7;
    model_reset();

    tbl[0] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 4'd0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 4'd0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 4'd1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 4'd2, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 4'd3, 1'b0};

    // done held high through and after reset must not start a replay
    frame_k();
    do_reset();
    for (int i = 0; i < 3; i++) step();
    ready = 1'b1;
    pulse_done();
    for (int i = 0; i < 18; i++) step();

    // table-driven start of a replay with stalls
    done = 1'b0;
    ready = 1'b0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      done = tbl[i].done;
      ready = tbl[i].ready;
      step();
      chk("tbl_valid", i, 32'(v0), 32'(tbl[i].exp_valid));
      chk("tbl_idx", i, 32'(idx0), 32'(tbl[i].exp_idx));
      chk("tbl_last", i, 32'(l0), 32'(tbl[i].exp_last));
    end
    ready = 1'b1;
    for (int i = 0; i < 16; i++) step();

    // back-to-back replay
    do_reset();
    frame_k();
    ready = 1'b1;
    pulse_done();
    for (int i = 0; i < 20; i++) step();
    chk("beats_full", 0, 32'(hs_cnt[0]), 32'd16);
    chk("beats_half", 1, 32'(hs_cnt[1]), 32'd8);

    // ready pattern 1,0,0,1
    do_reset();
    frame_k();
    pulse_done();
    for (int i = 0; i < 50; i++) begin
      ready = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    chk("beats_stall", 0, 32'(hs_cnt[0]), 32'd16);
    chk("beats_stall", 1, 32'(hs_cnt[1]), 32'd8);

    // second frame arriving mid-replay is dropped
    do_reset();
    frame_k();
    ready = 1'b1;
    pulse_done();
    fired = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (act[0] && pos[0] == 5 && !fired) begin
        fired = 1'b1;
        frame_rand();
        done = 1'b1;
      end else begin
        done = 1'b0;
      end
      step();
    end
    chk("overrun_sticky", 0, 32'(r0), 32'd1);

    // new frame on the final handshake continues without a gap
    do_reset();
    frame_k();
    ready = 1'b1;
    pulse_done();
    fired = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (act[0] && pos[0] == 15 && !fired) begin
        fired = 1'b1;
        frame_rand();
        done = 1'b1;
        step();
        chk("chain_valid", 0, 32'(v0), 32'd1);
        chk("chain_idx", 0, 32'(idx0), 32'd0);
        chk("chain_re", 0, 32'(dre0), 32'(bins_re[15:0]));
        chk("chain_overrun", 0, 32'(r0), 32'd0);
      end else begin
        done = 1'b0;
        step();
      end
    end

    // asynchronous reset in the middle of a replay
    do_reset();
    frame_k();
    ready = 1'b1;
    pulse_done();
    fired = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (act[0] && pos[0] == 7 && !fired) begin
        fired = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", 0, 32'(v0), 32'd0);
        chk("async_idx", 0, 32'(idx0), 32'd0);
        chk("async_valid", 1, 32'(v1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
      end else begin
        step();
      end
    end

`ifdef FFT_SER_MAG_EN
    do_reset();
    bins_re[15:0]  = 16'h0300;
    bins_im[15:0]  = 16'hFF00;
    bins_re[31:16] = 16'h8000;
    bins_im[31:16] = 16'h0000;
    ready = 1'b0;
    pulse_done();
    chk("mag_b0", 0, 32'(mag0), 32'h0380);
    ready = 1'b1;
    step();
    chk("mag_b1", 0, 32'(mag0), 32'h7FFF);
    for (int i = 0; i < 16; i++) step();
`endif

    // randomized traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) done = ~done;
      frame_rand();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
